// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the duty (high cycles per period) of an asynchronous PWM input,
// tracking period conformance and reporting static (non-toggling) levels as 0 or 15.
module pwm_decoder #(
  parameter int PERIOD = 16,
  parameter int TOL    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [3:0] value,
  output logic       valid,
  output logic       locked,
  output logic       err
);
  localparam int PMAX = PERIOD + TOL + 1;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int HW   = $clog2(PERIOD + 1);
  localparam int SW   = $clog2(PERIOD);
  typedef enum logic {ACQUIRE, TRACK} state_t;
  state_t          state_q, state_d;
  logic            meta_q, s_q, s_dly_q;
  logic [PW-1:0]   per_q, per_d;
  logic [HW-1:0]   hi_q, hi_d;
  logic [SW-1:0]   stb_q, stb_d;
  logic [3:0]      value_q, value_d;
  logic            valid_q, valid_d, locked_q, locked_d, err_q, err_d;
  logic            rise, edg, stat, conform, short_p;
  assign rise    = s_q & ~s_dly_q;
  assign edg     = s_q ^ s_dly_q;
  assign stat    = !edg && stb_q == SW'(PERIOD - 1);
  assign conform = per_q >= PW'(PERIOD - TOL) && per_q <= PW'(PERIOD + TOL);
  assign short_p = per_q < PW'(PERIOD - TOL);
  assign value   = value_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign err     = err_q;
  always_comb begin
    per_d    = rise ? PW'(1) : (per_q == PW'(PMAX) ? per_q : per_q + PW'(1));
    hi_d     = rise ? HW'(1) : ((s_q && hi_q != HW'(PERIOD)) ? hi_q + HW'(1) : hi_q);
    stb_d    = (edg || stat) ? '0 : stb_q + SW'(1);
    state_d  = state_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    if (stat) begin
      state_d  = ACQUIRE;
      value_d  = s_q ? 4'hf : 4'h0;
      valid_d  = 1'b1;
      locked_d = 1'b1;
    end else if (rise) begin
      state_d  = TRACK;
      // an acquiring rise only establishes the reference point
      value_d  = (state_q == TRACK && conform) ? ((int'(hi_q) > 15) ? 4'hf : 4'(hi_q)) : value_q;
      valid_d  = state_q == TRACK && conform;
      err_d    = state_q == TRACK && short_p;
      locked_d = state_q == TRACK ? conform : locked_q;
    end else if (state_q == TRACK && per_d == PW'(PMAX)) begin
      state_d  = ACQUIRE;
      locked_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      s_q      <= 1'b0;
      s_dly_q  <= 1'b0;
      per_q    <= '0;
      hi_q     <= '0;
      stb_q    <= '0;
      state_q  <= ACQUIRE;
      value_q  <= 4'h0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      meta_q   <= pwm_in;
      s_q      <= meta_q;
      s_dly_q  <= s_q;
      per_q    <= per_d;
      hi_q     <= hi_d;
      stb_q    <= stb_d;
      state_q  <= state_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed PWM waveforms; expected valid/err events queued with their cycle stamps.
module tb_pwm_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [3:0] value;
  logic       valid, locked, err;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  typedef struct {logic [3:0] v; int c;} exp_t;
  exp_t       vq[$];
  int         eq[$];
  pwm_decoder #(.PERIOD(16), .TOL(0)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .value(value), .valid(valid), .locked(locked), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  // monitor: every valid/err pulse must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (valid || err) chk("valid_err_exclusive", int'(valid && err), 0);
    if (valid) begin
      if (vq.size() == 0) chk("unexpected_valid_value", int'(value), -1);
      else begin
        e = vq.pop_front();
        chk("valid_value", int'(value), int'(e.v));
        chk("valid_cycle", cyc, e.c);
        chk("locked_at_valid", int'(locked), 1);
      end
    end
    if (err) begin
      if (eq.size() == 0) chk("unexpected_err_cycle", cyc, -1);
      else begin
        ec = eq.pop_front();
        chk("err_cycle", cyc, ec);
        chk("locked_at_err", int'(locked), 0);
      end
    end
  end
  task automatic idle(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = lvl;
    end
  endtask
  // one PWM period starting with a rise; expv < 0 means no valid expected from this rise
  task automatic period(input int h, input int l, input int expv, input bit experr);
    @(negedge clk);
    pwm_in = 1'b1;
    if (expv >= 0) vq.push_back('{4'(expv), cyc + 3});
    if (experr) eq.push_back(cyc + 3);
    for (int i = 1; i < h + l; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
    end
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    #2 rst = 1'b0;
    n = cyc;
    vq.push_back('{4'h0, n + 16});
    vq.push_back('{4'h0, n + 32});
    idle(40, 1'b0);
    chk("static_low_locked", int'(locked), 1);
    period(5, 11, -1, 0);
    repeat (3) period(5, 11, 5, 0);
    period(1, 15, 5, 0);
    period(1, 15, 1, 0);
    period(1, 15, 1, 0);
    period(15, 1, 1, 0);
    period(15, 1, 15, 0);
    period(15, 1, 15, 0);
    period(5, 11, 15, 0);
    period(5, 11, 5, 0);
    @(negedge clk);
    pwm_in = 1'b1;
    n = cyc;
    vq.push_back('{4'h5, n + 3});
    vq.push_back('{4'hf, n + 19});
    vq.push_back('{4'hf, n + 35});
    vq.push_back('{4'hf, n + 51});
    idle(55, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    n = cyc;
    vq.push_back('{4'h0, n + 19});
    vq.push_back('{4'h0, n + 35});
    idle(39, 1'b0);
    period(5, 11, -1, 0);
    period(5, 11, 5, 0);
    period(4, 8, 5, 0);
    repeat (3) period(4, 8, -1, 1);
    period(5, 11, -1, 1);
    chk("err_value_held", int'(value), 5);
    chk("err_unlocked", int'(locked), 0);
    period(5, 11, 5, 0);
    period(5, 11, 5, 0);
    @(negedge clk);
    pwm_in = 1'b1;
    vq.push_back('{4'h5, cyc + 3});
    idle(4, 1'b1);
    idle(2, 1'b0);
    chk("pre_rst_value", int'(value), 5);
    chk("pre_rst_locked", int'(locked), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_value", int'(value), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_err", int'(err), 0);
    idle(2, 1'b0);
    #2 rst = 1'b0;
    idle(5, 1'b0);
    period(5, 11, -1, 0);
    period(5, 11, 5, 0);
    period(5, 11, 5, 0);
    idle(6, 1'b0);
    chk("pending_valids", vq.size(), 0);
    chk("pending_errs", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
